// File: rtl/cla_addsub_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   ALU_WIDTH / CLA_GROUP / CLA_GPS : default width, bits per lookahead group,
//                                     groups per pipeline stage
//   FLAG_*                          : bit positions of C/V/Z/N in a flag vector
//   cla_lat()                       : pipeline depth for a given geometry
package cla_addsub_pipe_pkg;

   localparam int ALU_WIDTH = 16;
   localparam int CLA_GROUP = 4;
   localparam int CLA_GPS   = 2;

   localparam int FLAG_C = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;

   function automatic int cla_lat(input int width, input int group, input int gps);
      return width / (group * gps);
   endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
//   in_valid/in_ready   : operand handshake (in_ready driven by the adder)
//   in_a/in_b           : operands
//   in_sub/in_cin       : 1 = A - B; carry-in (add) or borrow-in (sub)
//   out_valid/out_ready : result handshake (out_ready driven by the consumer)
//   out_r, out_c/v/z/n  : result and status flags
// master = operand producer / result consumer, slave = the adder.
interface cla_addsub_pipe_if
   import cla_addsub_pipe_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_r;
   logic             out_c;
   logic             out_v;
   logic             out_z;
   logic             out_n;

   modport master (
      output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
      input  in_ready, out_valid, out_r, out_c, out_v, out_z, out_n
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
      output in_ready, out_valid, out_r, out_c, out_v, out_z, out_n
   );

endinterface

// File: rtl/cla_addsub_pipe_cla_group.sv
// GROUP-bit combinational carry-lookahead slice.
//   i_a, i_b : operand bits of this group (B already conditioned for subtract)
//   i_cin    : carry into the group's LSB
//   o_sum    : sum bits
//   o_g/o_p  : group generate / propagate for the next lookahead level
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] i_a,
   input  logic [GROUP-1:0] i_b,
   input  logic             i_cin,
   output logic [GROUP-1:0] o_sum,
   output logic             o_g,
   output logic             o_p
);

   logic [GROUP-1:0] w_g;
   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Every bit carry is a flat sum of products over g/p and i_cin, so no
   // carry ripples through a neighbouring bit.
   always_comb begin
      logic v_acc;
      logic v_pc;
      v_acc  = 1'b0;
      v_pc   = 1'b1;
      w_c    = '0;
      w_c[0] = i_cin;
      for (int j = 1; j < GROUP; j++) begin
         v_acc = 1'b0;
         v_pc  = 1'b1;
         for (int i = j - 1; i >= 0; i--) begin
            v_acc = v_acc | (w_g[i] & v_pc);
            v_pc  = v_pc & w_p[i];
         end
         w_c[j] = v_acc | (i_cin & v_pc);
      end
   end

   always_comb begin
      logic v_acc;
      logic v_pc;
      v_acc = 1'b0;
      v_pc  = 1'b1;
      for (int i = GROUP - 1; i >= 0; i--) begin
         v_acc = v_acc | (w_g[i] & v_pc);
         v_pc  = v_pc & w_p[i];
      end
      o_g = v_acc;
   end

   assign o_p   = &w_p;
   assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with C/V/Z/N flags and a
// valid/ready handshake.
//   CLK   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : cla_addsub_pipe_if.slave (operands in, result + flags out)
// Stage k resolves bits [k*GROUP*GPS +: GROUP*GPS] using the carry registered
// by stage k-1. Operand bits not yet consumed travel down with the op, and the
// low result bits already produced are carried along so the full result and
// flags emerge together from the last stage, LAT = WIDTH/(GROUP*GPS) edges
// after acceptance.
module cla_addsub_pipe
   import cla_addsub_pipe_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int GROUP = CLA_GROUP,
   parameter int GPS   = CLA_GPS
) (
   input  logic             CLK,
   input  logic             reset,
   cla_addsub_pipe_if.slave bus
);

   localparam int SW  = GROUP * GPS;
   localparam int LAT = cla_lat(WIDTH, GROUP, GPS);

   if (WIDTH % SW != 0) begin : g_bad_width
      $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP*GPS");
   end

   logic w_stall;
   logic w_en;
   logic w_accept;

   // A stalled result freezes the whole pipe; bubbles are kept in place so
   // ordering and per-op latency never change.
   assign w_stall      = bus.out_valid & ~bus.out_ready;
   assign w_en         = ~w_stall;
   assign bus.in_ready = w_en;
   assign w_accept     = bus.in_valid & w_en;

   for (genvar k = 0; k < LAT; k++) begin : g_stage
      logic [WIDTH-k*SW-1:0] w_op_a;
      logic [WIDTH-k*SW-1:0] w_op_b;
      logic [(k+1)*SW-1:0]   w_sum_all;
      logic [SW-1:0]         w_s;
      logic [GPS-1:0]        w_gg;
      logic [GPS-1:0]        w_gp;
      logic [GPS:0]          w_gc;
      logic                  w_cin;
      logic                  w_vin;
      logic                  r_vld;

      if (k == 0) begin : g_src
         // Subtract = A + ~B + 1; the +1 folds into the carry-in.
         assign w_op_a    = bus.in_a;
         assign w_op_b    = bus.in_b ^ {WIDTH{bus.in_sub}};
         assign w_cin     = bus.in_cin ^ bus.in_sub;
         assign w_vin     = w_accept;
         assign w_sum_all = w_s;
      end else begin : g_src
         assign w_op_a    = g_stage[k-1].g_mid.r_a;
         assign w_op_b    = g_stage[k-1].g_mid.r_b;
         assign w_cin     = g_stage[k-1].g_mid.r_c;
         assign w_vin     = g_stage[k-1].r_vld;
         assign w_sum_all = {w_s, g_stage[k-1].g_mid.r_s};
      end

      for (genvar j = 0; j < GPS; j++) begin : g_grp
         cla_group #(.GROUP(GROUP)) u_grp (
            .i_a   (w_op_a[j*GROUP +: GROUP]),
            .i_b   (w_op_b[j*GROUP +: GROUP]),
            .i_cin (w_gc[j]),
            .o_sum (w_s[j*GROUP +: GROUP]),
            .o_g   (w_gg[j]),
            .o_p   (w_gp[j])
         );
      end

      // Second lookahead level: group carries straight from group G/P and
      // the stage carry-in.
      always_comb begin
         logic v_acc;
         logic v_pc;
         v_acc   = 1'b0;
         v_pc    = 1'b1;
         w_gc    = '0;
         w_gc[0] = w_cin;
         for (int j = 1; j <= GPS; j++) begin
            v_acc = 1'b0;
            v_pc  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
               v_acc = v_acc | (w_gg[i] & v_pc);
               v_pc  = v_pc & w_gp[i];
            end
            w_gc[j] = v_acc | (w_cin & v_pc);
         end
      end

      always_ff @(posedge CLK or posedge reset) begin
         if (reset) begin
            r_vld <= 1'b0;
         end else if (w_en) begin
            r_vld <= w_vin;
         end
      end

      if (k < LAT - 1) begin : g_mid
         logic [WIDTH-(k+1)*SW-1:0] r_a;
         logic [WIDTH-(k+1)*SW-1:0] r_b;
         logic [(k+1)*SW-1:0]       r_s;
         logic                      r_c;

         always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
               r_a <= '0;
               r_b <= '0;
               r_s <= '0;
               r_c <= 1'b0;
            end else if (w_en && w_vin) begin
               r_a <= w_op_a[WIDTH-k*SW-1:SW];
               r_b <= w_op_b[WIDTH-k*SW-1:SW];
               r_s <= w_sum_all;
               r_c <= w_gc[GPS];
            end
         end
      end else begin : g_out
         logic [WIDTH-1:0]     r_r;
         logic [FLAG_N:FLAG_C] r_flg;
         logic                 w_msb_cin;

         // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
         assign w_msb_cin = w_s[SW-1] ^ w_op_a[SW-1] ^ w_op_b[SW-1];

         always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
               r_r   <= '0;
               r_flg <= '0;
            end else if (w_en && w_vin) begin
               r_r           <= w_sum_all;
               r_flg[FLAG_C] <= w_gc[GPS];
               r_flg[FLAG_V] <= w_gc[GPS] ^ w_msb_cin;
               r_flg[FLAG_Z] <= ~|w_sum_all;
               r_flg[FLAG_N] <= w_sum_all[WIDTH-1];
            end
         end
      end
   end

   assign bus.out_valid = g_stage[LAT-1].r_vld;
   assign bus.out_r     = g_stage[LAT-1].g_out.r_r;
   assign bus.out_c     = g_stage[LAT-1].g_out.r_flg[FLAG_C];
   assign bus.out_v     = g_stage[LAT-1].g_out.r_flg[FLAG_V];
   assign bus.out_z     = g_stage[LAT-1].g_out.r_flg[FLAG_Z];
   assign bus.out_n     = g_stage[LAT-1].g_out.r_flg[FLAG_N];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe at WIDTH=16, GROUP=4, GPS=2 (LAT=2).
module tb_cla_addsub_pipe;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   cla_addsub_pipe_if #(.WIDTH(16)) bus ();

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .GPS(2)) dut (
      .CLK   (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cin;
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
      logic        n;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   // {out_valid, out_r, C, V, Z, N}
   function automatic logic [20:0] exp_of(input vec_t t);
      return {1'b1, t.r, t.c, t.v, t.z, t.n};
   endfunction

   function automatic logic [20:0] obs();
      return {bus.out_valid, bus.out_r, bus.out_c, bus.out_v, bus.out_z, bus.out_n};
   endfunction

   task automatic drive(input vec_t t);
      bus.in_valid = 1'b1;
      bus.in_a     = t.a;
      bus.in_b     = t.b;
      bus.in_sub   = t.sub;
      bus.in_cin   = t.cin;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_a     = 16'h0000;
      bus.in_b     = 16'h0000;
      bus.in_sub   = 1'b0;
      bus.in_cin   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.in_ready, obs()} !== {1'b1, 21'h0}) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", {bus.in_ready, obs()}, {1'b1, 21'h0});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_valid: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         @(negedge clk);
         idle();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency[%0d]: out_valid got %b want 0", i, bus.out_valid);
         end
         @(negedge clk);
         checks++;
         if (obs() !== exp_of(vecs[i])) begin
            errors++;
            $display("FAIL single_result[%0d]: got %h want %h", i, obs(), exp_of(vecs[i]));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NV + 2; i++) begin
         @(negedge clk);
         if (i < 2) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL stream_prefill[%0d]: out_valid got %b want 0", i, bus.out_valid);
            end
         end else begin
            checks++;
            if ({bus.in_ready, obs()} !== {1'b1, exp_of(vecs[i-2])}) begin
               errors++;
               $display("FAIL stream_result[%0d]: got %h want %h", i - 2,
                        {bus.in_ready, obs()}, {1'b1, exp_of(vecs[i-2])});
            end
         end
         if (i < NV) drive(vecs[i]);
         else        idle();
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      vec_t op_a;
      vec_t op_b;
      vec_t op_c;
      op_a = '{a:16'h0001, b:16'h0001, sub:1'b0, cin:1'b0, r:16'h0002, c:1'b0, v:1'b0, z:1'b0, n:1'b0};
      op_b = vecs[6];
      op_c = '{a:16'h9000, b:16'h1000, sub:1'b1, cin:1'b0, r:16'h8000, c:1'b1, v:1'b0, z:1'b0, n:1'b1};
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(op_a);
      @(negedge clk);
      drive(op_b);
      @(negedge clk);
      drive(op_c);
      bus.out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.in_ready, obs()} !== {1'b0, exp_of(op_a)}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got %h want %h", i,
                     {bus.in_ready, obs()}, {1'b0, exp_of(op_a)});
         end
         @(negedge clk);
      end
      checks++;
      if (obs() !== exp_of(op_a)) begin
         errors++;
         $display("FAIL bp_hold_end: got %h want %h", obs(), exp_of(op_a));
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      idle();
      checks++;
      if (obs() !== exp_of(op_b)) begin
         errors++;
         $display("FAIL bp_second: got %h want %h", obs(), exp_of(op_b));
      end
      @(negedge clk);
      checks++;
      if (obs() !== exp_of(op_c)) begin
         errors++;
         $display("FAIL bp_third: got %h want %h", obs(), exp_of(op_c));
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_dup: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      drive(vecs[0]);
      @(negedge clk);
      drive(vecs[1]);
      @(negedge clk);
      idle();
      checks++;
      if (obs() !== exp_of(vecs[0])) begin
         errors++;
         $display("FAIL midrst_before: got %h want %h", obs(), exp_of(vecs[0]));
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, obs()} !== {1'b1, 21'h0}) begin
         errors++;
         $display("FAIL midrst_async: got %h want %h", {bus.in_ready, obs()}, {1'b1, 21'h0});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale[%0d]: out_valid got %b want 0", i, bus.out_valid);
         end
      end
   endtask

   initial begin
      vecs[0] = '{a:16'hFFFF, b:16'h0001, sub:1'b0, cin:1'b0, r:16'h0000, c:1'b1, v:1'b0, z:1'b1, n:1'b0};
      vecs[1] = '{a:16'h8000, b:16'h0001, sub:1'b1, cin:1'b0, r:16'h7FFF, c:1'b1, v:1'b1, z:1'b0, n:1'b0};
      vecs[2] = '{a:16'h0000, b:16'h0001, sub:1'b1, cin:1'b0, r:16'hFFFF, c:1'b0, v:1'b0, z:1'b0, n:1'b1};
      vecs[3] = '{a:16'h7FFF, b:16'h0001, sub:1'b0, cin:1'b0, r:16'h8000, c:1'b0, v:1'b1, z:1'b0, n:1'b1};
      vecs[4] = '{a:16'h1234, b:16'h4321, sub:1'b0, cin:1'b1, r:16'h5556, c:1'b0, v:1'b0, z:1'b0, n:1'b0};
      vecs[5] = '{a:16'h0005, b:16'h0003, sub:1'b1, cin:1'b1, r:16'h0001, c:1'b1, v:1'b0, z:1'b0, n:1'b0};
      vecs[6] = '{a:16'h00FF, b:16'h0001, sub:1'b0, cin:1'b0, r:16'h0100, c:1'b0, v:1'b0, z:1'b0, n:1'b0};
      vecs[7] = '{a:16'h0100, b:16'h0001, sub:1'b1, cin:1'b0, r:16'h00FF, c:1'b1, v:1'b0, z:1'b0, n:1'b0};
      vecs[8] = '{a:16'h1234, b:16'h1234, sub:1'b1, cin:1'b0, r:16'h0000, c:1'b1, v:1'b0, z:1'b1, n:1'b0};

      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
